// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register command sequencer: op codes,
// sel encoding, FSM states and the single-step shift function used by both
// the shadow register and the bench model.
package shift_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;
  localparam int MAX_W     = 32;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  localparam logic [1:0] SEL_SHR = 2'b00;
  localparam logic [1:0] SEL_SHL = 2'b01;
  localparam logic [1:0] SEL_ROL = 2'b10;
  localparam logic [1:0] SEL_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Next register value for one step; w is the live width (<= MAX_W), bits
  // above it are ignored on input and returned as zero.
  function automatic logic [MAX_W-1:0] shift_step(input logic [MAX_W-1:0] value,
                                                  input logic [1:0]       sel,
                                                  input int unsigned      w = DEF_WIDTH);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] v;
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    v    = value & mask;
    case (sel)
      SEL_SHR: return v >> 1;
      SEL_SHL: return (v << 1) & mask;
      SEL_ROL: return ((v << 1) | (v >> (w - 1))) & mask;
      default: return (v >> 1) | ((v & MAX_W'(1)) << (w - 1));
    endcase
  endfunction

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

  function automatic logic [1:0] op_to_sel(input logic [2:0] op);
    case (op)
      OP_SHL:  return SEL_SHL;
      OP_ROL:  return SEL_ROL;
      OP_ROR:  return SEL_ROR;
      default: return SEL_SHR;
    endcase
  endfunction

endpackage

// File: rtl/shift_shadow.sv
// Shadow copy of the downstream shift register. Loaded on LOAD cycles,
// stepped on RUN cycles, otherwise holds (the real register is held by
// re-loading this value).
module shift_shadow
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_en,
  input  logic             i_step_en,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic [1:0]       i_sel,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_step;

  assign w_step  = WIDTH'(shift_step(MAX_W'(r_value), i_sel, WIDTH));
  assign o_value = r_value;

  // Shadow register: reset to zero, load has priority over step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= '0;
    end else if (i_load_en) begin
      r_value <= i_load_value;
    end else if (i_step_en) begin
      r_value <= w_step;
    end
  end

endmodule

// File: rtl/shift_cmd_seq.sv
// Command sequencer in front of a 4-bit shift register with no enable.
// Expands LOAD / shift / rotate commands into per-cycle load/sel/ip and
// holds the register on idle cycles by re-loading the shadow value.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a command; register held by reloading mirror
//   ST_LOAD | one cycle driving the latched load value into the register
//   ST_RUN  | stepping the register once per cycle until count runs out
module shift_cmd_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             load,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] ip,
  output logic             done,
  output logic [WIDTH-1:0] mirror
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_remaining;
  logic             r_done;

  logic             w_accept;
  logic             w_run_start;
  logic             w_last;
  logic             w_done_next;
  logic             w_load_en;
  logic             w_step_en;
  logic [WIDTH-1:0] w_mirror;

  assign w_accept    = cmd_valid && (r_state == ST_IDLE);
  assign w_run_start = is_shift_op(cmd_op) && (cmd_count != '0);
  assign w_last      = (r_state == ST_RUN) && (r_remaining == CNT_W'(1));

  // Zero-step shifts and NOPs complete on the accept edge itself.
  assign w_done_next = (r_state == ST_LOAD) || w_last ||
                       (w_accept && (cmd_op != OP_LOAD) && !w_run_start);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cmd_op == OP_LOAD) begin
            w_state_next = ST_LOAD;
          end else if (w_run_start) begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_LOAD: w_state_next = ST_IDLE;
      ST_RUN:  if (w_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Command latches, step down-counter and registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_sel       <= SEL_SHR;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_next;
      if (w_accept && (cmd_op == OP_LOAD)) begin
        r_data <= cmd_data;
      end
      if (w_accept && w_run_start) begin
        r_sel       <= op_to_sel(cmd_op);
        r_remaining <= cmd_count;
      end else if (r_state == ST_RUN) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  // Outputs depend on registered state only, never on cmd_*.
  always_comb begin
    cmd_ready = 1'b0;
    load      = 1'b1;
    sel       = SEL_SHR;
    ip        = w_mirror;
    w_load_en = 1'b0;
    w_step_en = 1'b0;
    case (r_state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_LOAD: begin
        ip        = r_data;
        w_load_en = 1'b1;
      end
      ST_RUN: begin
        load      = 1'b0;
        sel       = r_sel;
        w_step_en = 1'b1;
      end
      default: ;
    endcase
  end

  shift_shadow #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load_en    (w_load_en),
    .i_step_en    (w_step_en),
    .i_load_value (r_data),
    .i_sel        (r_sel),
    .o_value      (w_mirror)
  );

  assign done   = r_done;
  assign mirror = w_mirror;

endmodule
